// File: rtl/reservation_station.sv
// Reservation station: buffers issued ops until both operands are final,
// snoops the ALU and load result broadcasts, and sends one ready op per cycle
// to the ALU through a registered dispatch packet.
// Optional feature macro: RS_BYPASS_EN. When defined, an issued op whose
// operands are already final is sent straight to the ALU if no stored entry
// is ready that cycle.
module reservation_station #(
  parameter int unsigned RS_SIZE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clr,
  input  logic        issue_enable,
  input  logic        rs_enable,
  input  logic [5:0]  issue_openum,
  input  logic [31:0] issue_rs1_val,
  input  logic [4:0]  issue_rs1_rob_pos,
  input  logic [31:0] issue_rs2_val,
  input  logic [4:0]  issue_rs2_rob_pos,
  input  logic [31:0] issue_imm,
  input  logic [31:0] issue_pc,
  input  logic [4:0]  issue_rob_pos,
  input  logic        alu_result_ready,
  input  logic [4:0]  alu_result_rob_pos,
  input  logic [31:0] alu_result_val,
  input  logic        lsb_load_result_ready,
  input  logic [4:0]  lsb_load_result_rob_pos,
  input  logic [31:0] lsb_load_result_val,
  output logic        rs_full,
  output logic        rs_to_alu_enable,
  output logic [5:0]  rs_to_alu_openum,
  output logic [31:0] rs_to_alu_rs1_val,
  output logic [31:0] rs_to_alu_rs2_val,
  output logic [31:0] rs_to_alu_imm,
  output logic [31:0] rs_to_alu_pc,
  output logic [4:0]  rs_to_alu_rob_pos
);

  localparam int unsigned IDX_W = $clog2(RS_SIZE);
  localparam int unsigned CNT_W = 6;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned POS_W = 5;
  localparam int unsigned OP_W  = 6;

  typedef struct packed {
    logic [XLEN-1:0]  val;
    logic [POS_W-1:0] pos;
  } operand_t;

  typedef struct packed {
    logic [OP_W-1:0]  openum;
    operand_t         rs1;
    operand_t         rs2;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic [POS_W-1:0] rob_pos;
  } entry_t;

  typedef struct packed {
    logic [OP_W-1:0]  openum;
    logic [XLEN-1:0]  rs1_val;
    logic [XLEN-1:0]  rs2_val;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic [POS_W-1:0] rob_pos;
  } dispatch_t;

  entry_t            ent_q [RS_SIZE];
  entry_t            ent_d [RS_SIZE];
  logic [RS_SIZE-1:0] valid_q, valid_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              en_q, en_d;
  dispatch_t         pkt_q, pkt_d;

  logic              issue_fire_c;
  entry_t            in_ent_c;
  logic              free_found_c;
  logic [IDX_W-1:0]  free_idx_c;
  logic              disp_found_c;
  logic [IDX_W-1:0]  disp_idx_c;
  logic              store_c;

  // A waiting operand picks up a matching broadcast value; pos 0 means final.
  function automatic operand_t snoop(input operand_t op);
    operand_t r;
    r = op;
    if (op.pos != '0) begin
      if (alu_result_ready && alu_result_rob_pos == op.pos) begin
        r.val = alu_result_val;
        r.pos = '0;
      end
      if (lsb_load_result_ready && lsb_load_result_rob_pos == op.pos) begin
        r.val = lsb_load_result_val;
        r.pos = '0;
      end
    end
    return r;
  endfunction

  function automatic dispatch_t to_dispatch(input entry_t e);
    dispatch_t p;
    p.openum  = e.openum;
    p.rs1_val = e.rs1.val;
    p.rs2_val = e.rs2.val;
    p.imm     = e.imm;
    p.pc      = e.pc;
    p.rob_pos = e.rob_pos;
    return p;
  endfunction

  // Incoming packet with operands already snooped against this cycle's broadcasts.
  always_comb begin
    issue_fire_c     = issue_enable & rs_enable;
    in_ent_c.openum  = issue_openum;
    in_ent_c.rs1     = snoop(operand_t'({issue_rs1_val, issue_rs1_rob_pos}));
    in_ent_c.rs2     = snoop(operand_t'({issue_rs2_val, issue_rs2_rob_pos}));
    in_ent_c.imm     = issue_imm;
    in_ent_c.pc      = issue_pc;
    in_ent_c.rob_pos = issue_rob_pos;
  end

`ifdef RS_BYPASS_EN
  logic bypass_c;
  assign bypass_c = issue_fire_c && (in_ent_c.rs1.pos == '0) &&
                    (in_ent_c.rs2.pos == '0) && !disp_found_c;
`endif

  // Lowest free slot for storage and lowest ready entry for dispatch.
  always_comb begin
    free_found_c = 1'b0;
    free_idx_c   = '0;
    disp_found_c = 1'b0;
    disp_idx_c   = '0;
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      if (!free_found_c && !valid_q[i]) begin
        free_found_c = 1'b1;
        free_idx_c   = IDX_W'(i);
      end
      if (!disp_found_c && valid_q[i] &&
          ent_q[i].rs1.pos == '0 && ent_q[i].rs2.pos == '0) begin
        disp_found_c = 1'b1;
        disp_idx_c   = IDX_W'(i);
      end
    end
  end

  // Next state: flush, broadcast capture, dispatch, then store of the new packet.
  always_comb begin
    valid_d = valid_q;
    ent_d   = ent_q;
    count_d = count_q;
    en_d    = en_q;
    pkt_d   = pkt_q;
    store_c = 1'b0;
    if (rdy) begin
      if (clr) begin
        valid_d = '0;
        count_d = '0;
        en_d    = 1'b0;
      end else begin
        en_d = 1'b0;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
          if (valid_q[i]) begin
            ent_d[i].rs1 = snoop(ent_q[i].rs1);
            ent_d[i].rs2 = snoop(ent_q[i].rs2);
          end
        end
        if (disp_found_c) begin
          valid_d[disp_idx_c] = 1'b0;
          en_d                = 1'b1;
          pkt_d               = to_dispatch(ent_q[disp_idx_c]);
        end
`ifdef RS_BYPASS_EN
        else if (bypass_c) begin
          en_d  = 1'b1;
          pkt_d = to_dispatch(in_ent_c);
        end
        store_c = issue_fire_c && free_found_c && !bypass_c;
`else
        store_c = issue_fire_c && free_found_c;
`endif
        if (store_c) begin
          valid_d[free_idx_c] = 1'b1;
          ent_d[free_idx_c]   = in_ent_c;
        end
        count_d = count_q + CNT_W'(store_c) - CNT_W'(disp_found_c);
      end
    end
  end

  // Control state and dispatch packet, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      count_q <= '0;
      en_q    <= 1'b0;
      pkt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      en_q    <= en_d;
      pkt_q   <= pkt_d;
    end
  end

  // Entry payload; only meaningful while its valid bit is set.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  assign rs_full           = (count_q >= CNT_W'(RS_SIZE - 1));
  assign rs_to_alu_enable  = en_q;
  assign rs_to_alu_openum  = pkt_q.openum;
  assign rs_to_alu_rs1_val = pkt_q.rs1_val;
  assign rs_to_alu_rs2_val = pkt_q.rs2_val;
  assign rs_to_alu_imm     = pkt_q.imm;
  assign rs_to_alu_pc      = pkt_q.pc;
  assign rs_to_alu_rob_pos = pkt_q.rob_pos;

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station (default build): directed vector table,
// hand-written multi-cycle sequences, and random traffic against a model.
module tb_reservation_station;
  localparam int RS = 16;

  logic        clk = 1'b0;
  logic        rst, rdy, clr, issue_en, rs_en;
  logic [5:0]  opn;
  logic [31:0] rs1v, rs2v, immv, pcv;
  logic [4:0]  rs1p, rs2p, robp;
  logic        alu_rdy, lsb_rdy;
  logic [4:0]  alu_pos, lsb_pos;
  logic [31:0] alu_val, lsb_val;
  logic        full, d_en;
  logic [5:0]  d_op;
  logic [31:0] d_v1, d_v2, d_imm, d_pc;
  logic [4:0]  d_rob;

  always #5 clk = ~clk;

  reservation_station #(.RS_SIZE(RS)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .issue_enable(issue_en), .rs_enable(rs_en),
    .issue_openum(opn), .issue_rs1_val(rs1v), .issue_rs1_rob_pos(rs1p),
    .issue_rs2_val(rs2v), .issue_rs2_rob_pos(rs2p), .issue_imm(immv),
    .issue_pc(pcv), .issue_rob_pos(robp),
    .alu_result_ready(alu_rdy), .alu_result_rob_pos(alu_pos), .alu_result_val(alu_val),
    .lsb_load_result_ready(lsb_rdy), .lsb_load_result_rob_pos(lsb_pos),
    .lsb_load_result_val(lsb_val),
    .rs_full(full), .rs_to_alu_enable(d_en), .rs_to_alu_openum(d_op),
    .rs_to_alu_rs1_val(d_v1), .rs_to_alu_rs2_val(d_v2), .rs_to_alu_imm(d_imm),
    .rs_to_alu_pc(d_pc), .rs_to_alu_rob_pos(d_rob)
  );

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // ---------------- reference model ----------------
  bit          mval [RS];
  logic [5:0]  mop  [RS];
  logic [4:0]  mp1 [RS], mp2 [RS], mrob [RS];
  logic [31:0] mv1 [RS], mv2 [RS], mimm [RS], mpc [RS];
  logic        m_en;
  logic [5:0]  m_op;
  logic [4:0]  m_rob;
  logic [31:0] m_v1, m_v2, m_imm, m_pc;

  task automatic model_reset();
    for (int i = 0; i < RS; i++) mval[i] = 1'b0;
    m_en = 1'b0; m_op = '0; m_rob = '0; m_v1 = '0; m_v2 = '0; m_imm = '0; m_pc = '0;
  endtask

  // Operand after the broadcasts on the bus this cycle: returns {pos, val}.
  function automatic logic [36:0] res(input logic [4:0] p, input logic [31:0] v);
    if (p != 5'd0 && alu_rdy && alu_pos == p) return {5'd0, alu_val};
    if (p != 5'd0 && lsb_rdy && lsb_pos == p) return {5'd0, lsb_val};
    return {p, v};
  endfunction

  function automatic bit model_full();
    int n = 0;
    for (int i = 0; i < RS; i++) if (mval[i]) n++;
    return n >= RS - 1;
  endfunction

  task automatic model_step();
    int d = -1;
    int f = -1;
    if (!rdy) return;
    if (clr) begin
      for (int i = 0; i < RS; i++) mval[i] = 1'b0;
      m_en = 1'b0;
      return;
    end
    for (int i = 0; i < RS; i++) begin
      if (d < 0 && mval[i] && mp1[i] == 5'd0 && mp2[i] == 5'd0) d = i;
      if (f < 0 && !mval[i]) f = i;
    end
    for (int i = 0; i < RS; i++) if (mval[i]) begin
      {mp1[i], mv1[i]} = res(mp1[i], mv1[i]);
      {mp2[i], mv2[i]} = res(mp2[i], mv2[i]);
    end
    m_en = (d >= 0);
    if (d >= 0) begin
      m_op = mop[d]; m_v1 = mv1[d]; m_v2 = mv2[d];
      m_imm = mimm[d]; m_pc = mpc[d]; m_rob = mrob[d];
      mval[d] = 1'b0;
    end
    if (issue_en && rs_en && f >= 0) begin
      mval[f] = 1'b1; mop[f] = opn; mimm[f] = immv; mpc[f] = pcv; mrob[f] = robp;
      {mp1[f], mv1[f]} = res(rs1p, rs1v);
      {mp2[f], mv2[f]} = res(rs2p, rs2v);
    end
  endtask

  task automatic check_model(input int cyc);
    chk($sformatf("rnd%0d_en", cyc), 32'(d_en), 32'(m_en));
    chk($sformatf("rnd%0d_full", cyc), 32'(full), 32'(model_full()));
    chk($sformatf("rnd%0d_op", cyc), 32'(d_op), 32'(m_op));
    chk($sformatf("rnd%0d_rob", cyc), 32'(d_rob), 32'(m_rob));
    chk($sformatf("rnd%0d_v1", cyc), d_v1, m_v1);
    chk($sformatf("rnd%0d_v2", cyc), d_v2, m_v2);
    chk($sformatf("rnd%0d_imm", cyc), d_imm, m_imm);
    chk($sformatf("rnd%0d_pc", cyc), d_pc, m_pc);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    rdy = 1'b1; clr = 1'b0; issue_en = 1'b0; rs_en = 1'b0;
    alu_rdy = 1'b0; lsb_rdy = 1'b0;
  endtask

  task automatic set_issue(input logic [4:0] rob, input logic [4:0] p1, input logic [31:0] v1,
                           input logic [4:0] p2, input logic [31:0] v2);
    issue_en = 1'b1; rs_en = 1'b1; opn = 6'd1; robp = rob;
    rs1p = p1; rs1v = v1; rs2p = p2; rs2v = v2;
    immv = 32'h100 + 32'(rob); pcv = 32'h4000 + 32'(rob) * 4;
  endtask

  task automatic alu_bcast(input logic [4:0] p, input logic [31:0] v);
    alu_rdy = 1'b1; alu_pos = p; alu_val = v;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rdy, iss, rse;
    logic [4:0]  rob, p1, p2;
    logic [31:0] v1, v2;
    logic        av;
    logic [4:0]  ap;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lp;
    logic [31:0] ld;
    logic        e_en;
    logic [4:0]  e_rob;
    logic [31:0] e_v1, e_v2;
    logic        e_full;
  } vec_t;

  function automatic vec_t idle_row(input logic r, input logic en, input logic [4:0] rob,
                                    input logic [31:0] e1, input logic [31:0] e2);
    vec_t v = '{default: '0};
    v.rdy = r; v.e_en = en; v.e_rob = rob; v.e_v1 = e1; v.e_v2 = e2;
    return v;
  endfunction

  function automatic vec_t issue_row(input logic r, input logic rse, input logic [4:0] rob,
                                     input logic [4:0] p1, input logic [31:0] v1,
                                     input logic [4:0] p2, input logic [31:0] v2,
                                     input logic lv, input logic [4:0] lp, input logic [31:0] ld);
    vec_t v = '{default: '0};
    v.rdy = r; v.iss = 1'b1; v.rse = rse; v.rob = rob;
    v.p1 = p1; v.v1 = v1; v.p2 = p2; v.v2 = v2; v.lv = lv; v.lp = lp; v.ld = ld;
    return v;
  endfunction

  function automatic vec_t bcast_row(input logic r, input logic [4:0] ap, input logic [31:0] ad);
    vec_t v = '{default: '0};
    v.rdy = r; v.av = 1'b1; v.ap = ap; v.ad = ad;
    return v;
  endfunction

  vec_t tbl [24];

  initial begin
    logic [4:0] lp_r;

    tbl[0]  = issue_row(1'b1, 1'b1, 5'd3, 5'd0, 32'd5, 5'd0, 32'd7, 1'b0, 5'd0, 32'd0);
    tbl[1]  = idle_row(1'b1, 1'b1, 5'd3, 32'd5, 32'd7);
    tbl[2]  = idle_row(1'b1, 1'b0, 5'd0, 32'd0, 32'd0);
    tbl[3]  = issue_row(1'b1, 1'b1, 5'd8, 5'd4, 32'd0, 5'd0, 32'd9, 1'b0, 5'd0, 32'd0);
    tbl[4]  = idle_row(1'b1, 1'b0, 5'd0, 32'd0, 32'd0);
    tbl[5]  = idle_row(1'b1, 1'b0, 5'd0, 32'd0, 32'd0);
    tbl[6]  = bcast_row(1'b1, 5'd4, 32'h1234);
    tbl[7]  = idle_row(1'b1, 1'b1, 5'd8, 32'h1234, 32'd9);
    tbl[8]  = issue_row(1'b1, 1'b1, 5'd10, 5'd0, 32'd1, 5'd6, 32'd0, 1'b1, 5'd6, 32'hFF);
    tbl[9]  = idle_row(1'b1, 1'b1, 5'd10, 32'd1, 32'hFF);
    tbl[10] = idle_row(1'b1, 1'b0, 5'd0, 32'd0, 32'd0);
    tbl[11] = issue_row(1'b0, 1'b1, 5'd12, 5'd0, 32'd2, 5'd0, 32'd3, 1'b0, 5'd0, 32'd0);
    tbl[12] = idle_row(1'b1, 1'b0, 5'd0, 32'd0, 32'd0);
    tbl[13] = issue_row(1'b1, 1'b1, 5'd13, 5'd0, 32'd4, 5'd0, 32'd5, 1'b0, 5'd0, 32'd0);
    tbl[14] = idle_row(1'b1, 1'b1, 5'd13, 32'd4, 32'd5);
    tbl[15] = idle_row(1'b0, 1'b1, 5'd13, 32'd4, 32'd5);
    tbl[16] = idle_row(1'b1, 1'b0, 5'd0, 32'd0, 32'd0);
    tbl[17] = issue_row(1'b1, 1'b0, 5'd14, 5'd0, 32'd6, 5'd0, 32'd7, 1'b0, 5'd0, 32'd0);
    tbl[18] = idle_row(1'b1, 1'b0, 5'd0, 32'd0, 32'd0);
    tbl[19] = issue_row(1'b1, 1'b1, 5'd15, 5'd9, 32'd0, 5'd0, 32'd1, 1'b0, 5'd0, 32'd0);
    tbl[20] = bcast_row(1'b0, 5'd9, 32'hAA);
    tbl[21] = idle_row(1'b1, 1'b0, 5'd0, 32'd0, 32'd0);
    tbl[22] = bcast_row(1'b1, 5'd9, 32'hBB);
    tbl[23] = idle_row(1'b1, 1'b1, 5'd15, 32'hBB, 32'd1);

    // Asynchronous reset: outputs must clear without a clock edge.
    opn = '0; rs1v = '0; rs2v = '0; immv = '0; pcv = '0; rs1p = '0; rs2p = '0; robp = '0;
    alu_pos = '0; alu_val = '0; lsb_pos = '0; lsb_val = '0;
    idle();
    rst = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("reset_en", 32'(d_en), 32'd0);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_rob", 32'(d_rob), 32'd0);
    chk("reset_v1", d_v1, 32'd0);
    chk("reset_pc", d_pc, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // Directed vectors.
    for (int k = 0; k < 24; k++) begin
      rdy = tbl[k].rdy; issue_en = tbl[k].iss; rs_en = tbl[k].rse;
      opn = 6'd1; robp = tbl[k].rob; rs1p = tbl[k].p1; rs1v = tbl[k].v1;
      rs2p = tbl[k].p2; rs2v = tbl[k].v2; immv = 32'd0; pcv = 32'd0;
      alu_rdy = tbl[k].av; alu_pos = tbl[k].ap; alu_val = tbl[k].ad;
      lsb_rdy = tbl[k].lv; lsb_pos = tbl[k].lp; lsb_val = tbl[k].ld;
      step();
      chk($sformatf("vec%0d_en", k), 32'(d_en), 32'(tbl[k].e_en));
      chk($sformatf("vec%0d_full", k), 32'(full), 32'(tbl[k].e_full));
      if (tbl[k].e_en) begin
        chk($sformatf("vec%0d_rob", k), 32'(d_rob), 32'(tbl[k].e_rob));
        chk($sformatf("vec%0d_v1", k), d_v1, tbl[k].e_v1);
        chk($sformatf("vec%0d_v2", k), d_v2, tbl[k].e_v2);
      end
    end

    // Fill to capacity, drop when completely full, drain below threshold.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      set_issue(5'(i + 1), 5'(i + 1), 32'd0, 5'd0, 32'(i));
      step();
      if (i == 13) chk("fill14_full", 32'(full), 32'd0);
    end
    chk("fill15_full", 32'(full), 32'd1);
    set_issue(5'd16, 5'd16, 32'd0, 5'd0, 32'd0); step();
    chk("fill16_full", 32'(full), 32'd1);
    chk("fill16_en", 32'(d_en), 32'd0);
    set_issue(5'd17, 5'd31, 32'd0, 5'd0, 32'd0); step();
    chk("fill17_full", 32'(full), 32'd1);
    alu_bcast(5'd1, 32'h55); step();
    chk("fill_bc1_en", 32'(d_en), 32'd0);
    step();
    chk("fill_d1_en", 32'(d_en), 32'd1);
    chk("fill_d1_rob", 32'(d_rob), 32'd1);
    chk("fill_d1_v1", d_v1, 32'h55);
    chk("fill_d1_full", 32'(full), 32'd1);
    alu_bcast(5'd2, 32'h66); step(); step();
    chk("fill_d2_en", 32'(d_en), 32'd1);
    chk("fill_d2_rob", 32'(d_rob), 32'd2);
    chk("fill_d2_v2", d_v2, 32'd1);
    chk("fill_d2_full", 32'(full), 32'd0);
    alu_bcast(5'd31, 32'h77); step(); step();
    chk("fill_drop_en", 32'(d_en), 32'd0);

    // Flush with 8 pending entries and a same-cycle issue.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_issue(5'(i + 1), 5'(i + 1), 32'd0, 5'd0, 32'd0);
      step();
    end
    clr = 1'b1;
    set_issue(5'd20, 5'd0, 32'd1, 5'd0, 32'd2);
    step();
    chk("clr_en", 32'(d_en), 32'd0);
    chk("clr_full", 32'(full), 32'd0);
    alu_bcast(5'd1, 32'h99); step();
    chk("clr_bc_en0", 32'(d_en), 32'd0);
    step();
    chk("clr_bc_en1", 32'(d_en), 32'd0);
    step();
    chk("clr_bc_en2", 32'(d_en), 32'd0);
    for (int i = 0; i < 14; i++) begin
      set_issue(5'(i + 1), 5'd30, 32'd0, 5'd0, 32'd0);
      step();
    end
    chk("clr_cnt14_full", 32'(full), 32'd0);
    set_issue(5'd15, 5'd30, 32'd0, 5'd0, 32'd0); step();
    chk("clr_cnt15_full", 32'(full), 32'd1);

    // Reset in the middle of activity, with a dispatch pending.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_issue(5'(i + 1), 5'(i + 1), 32'd0, 5'd0, 32'd0);
      step();
    end
    set_issue(5'd21, 5'd0, 32'hA, 5'd0, 32'hB); step();
    set_issue(5'd22, 5'd0, 32'd1, 5'd0, 32'd2); step();
    chk("mid_pre_en", 32'(d_en), 32'd1);
    chk("mid_pre_rob", 32'(d_rob), 32'd21);
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_en", 32'(d_en), 32'd0);
    chk("mid_rst_rob", 32'(d_rob), 32'd0);
    chk("mid_rst_v1", d_v1, 32'd0);
    chk("mid_rst_v2", d_v2, 32'd0);
    chk("mid_rst_imm", d_imm, 32'd0);
    chk("mid_rst_full", 32'(full), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    alu_bcast(5'd1, 32'h11); step();
    chk("post_rst_en0", 32'(d_en), 32'd0);
    step();
    chk("post_rst_en1", 32'(d_en), 32'd0);
    step();
    chk("post_rst_en2", 32'(d_en), 32'd0);
    set_issue(5'd23, 5'd0, 32'd3, 5'd0, 32'd4); step();
    chk("post_rst_lat1", 32'(d_en), 32'd0);
    step();
    chk("post_rst_lat2", 32'(d_en), 32'd1);
    chk("post_rst_rob", 32'(d_rob), 32'd23);
    chk("post_rst_v1", d_v1, 32'd3);
    chk("post_rst_v2", d_v2, 32'd4);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      rdy      = ($urandom % 10) != 0;
      clr      = ($urandom % 40) == 0;
      issue_en = ($urandom % 2) == 0;
      rs_en    = ($urandom % 4) != 0;
      opn      = 6'($urandom);
      robp     = 5'($urandom_range(1, 31));
      rs1p     = (($urandom % 3) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
      rs2p     = (($urandom % 3) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
      rs1v     = $urandom; rs2v = $urandom; immv = $urandom; pcv = $urandom;
      alu_rdy  = ($urandom % 3) == 0;
      alu_pos  = 5'($urandom_range(1, 7));
      alu_val  = $urandom;
      lsb_rdy  = ($urandom % 3) == 0;
      lp_r     = 5'($urandom_range(1, 7));
      lsb_pos  = lp_r;
      lsb_val  = $urandom;
      if (alu_rdy && lsb_rdy && alu_pos == lsb_pos) lsb_rdy = 1'b0;
      step();
      check_model(c);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 Parameter: RS_SIZE, default 16, number of entries; power of two, 4..32.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 rdy / clr  in  1 each  global stall / misprediction flush.
REQ-005 issue_enable, rs_enable  in  1 each  issue packet valid and targeted at this block; accepted only when both are high.
REQ-006 issue_openum 6, issue_rs1_val 32, issue_rs1_rob_pos 5, issue_rs2_val 32, issue_rs2_rob_pos 5, issue_imm 32, issue_pc 32, issue_rob_pos 5  in  issue packet fields; rob_pos 0 means the operand value is final.
REQ-007 alu_result_ready 1, alu_result_rob_pos 5, alu_result_val 32  in  ALU broadcast.
REQ-008 lsb_load_result_ready 1, lsb_load_result_rob_pos 5, lsb_load_result_val 32  in  load broadcast.
REQ-009 rs_full  out  1  back-pressure to ifetch.
REQ-010 rs_to_alu_enable 1, rs_to_alu_openum 6, rs_to_alu_rs1_val 32, rs_to_alu_rs2_val 32, rs_to_alu_imm 32, rs_to_alu_pc 32, rs_to_alu_rob_pos 5  out  registered dispatch packet.

Function
REQ-011 Entry: valid, openum, two (val, rob_pos) operand pairs, imm, pc, rob_pos; operand ready when its rob_pos is 0.
REQ-012 Accepted packet written at the next edge into the lowest-index invalid entry.
REQ-013 Each edge, every valid entry with rob_pos==X (X!=0) for any asserted broadcast takes that broadcast's val and sets rob_pos to 0; ALU and LSB broadcasts are applied independently within the same edge.
REQ-014 Accepted packet operands are also compared against the same-cycle broadcasts and captured before storage.
REQ-015 Each edge, the lowest-index valid entry with both operands ready is removed and its fields registered onto rs_to_alu_*, with rs_to_alu_enable=1 for exactly one cycle; if none ready, rs_to_alu_enable=0 and data outputs hold.
REQ-016 Operand values driven to the ALU are the entry's values after REQ-013 updates in that edge's prior cycle; an entry ready only via a same-cycle broadcast dispatches one edge later.
REQ-017 Latency, issue to rs_to_alu_enable with operands ready: 2 edges (store, then dispatch).
REQ-018 Issue and dispatch in the same cycle are both performed; the freed entry is reusable the following cycle.
REQ-019 rs_full is combinational, high when valid-entry count >= RS_SIZE-1 (one slot of slack for the registered fetch stage).
REQ-020 Packet accepted while all RS_SIZE entries are valid is dropped; state unchanged.
REQ-021 rdy low: all state and outputs hold; issue and broadcasts in that cycle are ignored.
REQ-022 clr high (with rdy): at next edge all entries invalidated, rs_to_alu_enable=0, any same-cycle issue discarded; clr takes priority over issue, broadcast and dispatch.
REQ-023 Occupancy counter is 6 bits, never wraps; incremented/decremented consistently with REQ-018.

Reset
REQ-024 rst low asynchronously clears all valid bits, counter and every rs_to_alu_* output to 0; rs_full reads 0.
REQ-025 Reset during a pending dispatch suppresses it; first dispatch possible 2 edges after first post-reset issue.

Configuration
REQ-026 Macro RS_BYPASS_EN: when defined, an accepted packet with both operands ready (after REQ-014) and no ready stored entry is registered directly onto rs_to_alu_* at the next edge without occupying an entry (latency 1).
REQ-027 Without RS_BYPASS_EN, every accepted packet is stored; latency per REQ-017; no bypass logic synthesized.

Verification
REQ-028 Issue ADD, rs1_rob_pos=0 val=5, rs2_rob_pos=0 val=7, rob_pos=3 -> rs_to_alu_enable=1 after 2 edges (1 with RS_BYPASS_EN), rs1=5, rs2=7, rob_pos=3.
REQ-029 Issue with rs1_rob_pos=4; 3 cycles later ALU broadcasts rob_pos=4 val=0x1234 -> dispatch next edge with rs1_val=0x1234.
REQ-030 Same-cycle issue rs2_rob_pos=6 and load broadcast rob_pos=6 val=0xFF -> stored ready, dispatched with rs2_val=0xFF.
REQ-031 Fill 15 entries all waiting -> rs_full=1; 16th accepted; 17th dropped; broadcast resolves entry 0 -> dispatched, rs_full stays 1 until count<=14.
REQ-032 8 entries pending, clr pulse -> next edge count 0, rs_to_alu_enable=0, later broadcast matching old rob_pos produces no dispatch.
REQ-033 rst low mid-operation with 5 entries -> outputs 0 immediately, no dispatch after rst release.
